// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared FSM state type and APB bus widths for the arbitrated APB master.
package apb_arb_pkg;
    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
endpackage

// File: rtl/apb_rr_arb.sv
// apb_rr_arb: round-robin grant, searching upward from last+1 (mod N).
module apb_rr_arb
    import apb_arb_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] c;
    always_comb begin
        grant = '0;
        idx = '0;
        c = '0;
        // Walk from the farthest candidate down so the nearest requester is written last and wins.
        for (int k = N; k >= 1; k--) begin
            c = IW'((int'(last) + k) % N);
            if (req[c]) begin
                grant = '0;
                grant[c] = 1'b1;
                idx = c;
            end
        end
    end
endmodule

// File: rtl/apb_arb_master.sv
// apb_arb_master: round-robin arbiter in front of a single APB master port.
// Define APB_ARB_TIMEOUT_EN to end ACCESS with an error after TIMEOUT_CYCLES wait states.
module apb_arb_master
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          pclk,
    input  logic                          presetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*APB_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*APB_DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [APB_DATA_W-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic [APB_ADDR_W-1:0]         paddr,
    output logic                          psel,
    output logic                          penable,
    output logic                          pwrite,
    output logic [APB_DATA_W-1:0]         pwdata,
    input  logic [APB_DATA_W-1:0]         prdata,
    input  logic                          pready,
    input  logic                          pslverr
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef APB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    state_t state, state_n;
    logic [IW-1:0] last_grant, cur, gidx;
    logic [NUM_REQ-1:0] grant;
    logic [CW-1:0] cnt;
    logic done, to, accept;

    apb_rr_arb #(.N(NUM_REQ)) u_arb (
        .req(req_valid),
        .last(last_grant),
        .grant(grant),
        .idx(gidx)
    );

    assign to = TO_EN && state == ACCESS && !pready && cnt == CW'(TIMEOUT_CYCLES - 1);
    assign done = state == ACCESS && (pready || to);
    assign accept = presetn && |req_valid && (state == IDLE || done);
    assign req_ready = accept ? grant : '0;
    assign psel = state != IDLE;
    assign penable = state == ACCESS;

    always_comb begin
        state_n = IDLE;
        state_n = accept ? SETUP : state == SETUP ? ACCESS : (state == ACCESS && !done) ? ACCESS : IDLE;
    end

    always_ff @(posedge pclk) begin
        if (!presetn)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            last_grant <= IW'(NUM_REQ - 1);
            cur <= '0;
            cnt <= '0;
            paddr <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err <= 1'b0;
        end else begin
            rsp_valid <= done ? NUM_REQ'(1) << cur : '0;
            rsp_rdata <= (done && !pwrite && !to) ? prdata : '0;
            rsp_err <= done && (to || pslverr);
            cnt <= accept ? '0 : (state == ACCESS && !pready) ? cnt + 1'b1 : cnt;
            if (accept) begin
                last_grant <= gidx;
                cur <= gidx;
                paddr <= req_addr[APB_ADDR_W*gidx +: APB_ADDR_W];
                pwrite <= req_write[gidx];
                pwdata <= req_wdata[APB_DATA_W*gidx +: APB_DATA_W];
            end
        end
    end
endmodule

// File: tb/tb_apb_arb_master.sv
// tb_apb_arb_master: directed checks of arbitration, APB timing, errors and reset abort.
module tb_apb_arb_master;
    logic        pclk = 1'b0;
    logic        presetn;
    logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
    logic [63:0] req_addr, req_wdata;
    logic [31:0] rsp_rdata, paddr, pwdata, prdata;
    logic        rsp_err, psel, penable, pwrite, pready, pslverr;
    int vec = 0;
    int errs = 0;

    apb_arb_master #(.NUM_REQ(2), .TIMEOUT_CYCLES(16)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic test_reset;
        presetn = 1'b0; req_valid = 2'b11; req_write = 2'b11;
        req_addr = {32'h200, 32'h100}; req_wdata = 64'h0;
        prdata = 32'h0; pready = 1'b1; pslverr = 1'b0;
        @(negedge pclk); @(negedge pclk);
        vec++; if ({psel, penable, pwrite, rsp_err} !== 4'b0) begin errs++; $display("FAIL reset_ctrl: got %b expected 0000", {psel, penable, pwrite, rsp_err}); end
        vec++; if ({req_ready, rsp_valid} !== 4'b0) begin errs++; $display("FAIL reset_hs: got %b expected 0000", {req_ready, rsp_valid}); end
        vec++; if ({paddr, pwdata, rsp_rdata} !== 96'h0) begin errs++; $display("FAIL reset_data: got %h expected 0", {paddr, pwdata, rsp_rdata}); end
        req_valid = 2'b00;
        presetn = 1'b1;
    endtask

    task automatic test_single_write;
        req_valid = 2'b01; req_addr[31:0] = 32'h40; req_write = 2'b01; req_wdata[31:0] = 32'hDEADBEEF; pready = 1'b1;
        #1;
        vec++; if (req_ready !== 2'b01) begin errs++; $display("FAIL wr_ready: got %b expected 01", req_ready); end
        @(negedge pclk);
        req_valid = 2'b00;
        vec++; if ({psel, penable, pwrite, paddr, pwdata} !== {3'b101, 32'h40, 32'hDEADBEEF}) begin errs++; $display("FAIL wr_setup: got %b %h %h expected 101 40 deadbeef", {psel, penable, pwrite}, paddr, pwdata); end
        @(negedge pclk);
        vec++; if ({psel, penable, rsp_valid} !== 4'b1100) begin errs++; $display("FAIL wr_access: got %b expected 1100", {psel, penable, rsp_valid}); end
        @(negedge pclk);
        vec++; if ({rsp_valid, rsp_err, psel, rsp_rdata} !== {2'b01, 2'b00, 32'h0}) begin errs++; $display("FAIL wr_rsp: got %b %b %b %h expected 01 0 0 0", rsp_valid, rsp_err, psel, rsp_rdata); end
    endtask

    task automatic test_wait_read;
        req_valid = 2'b01; req_addr[31:0] = 32'h80; req_write = 2'b00; pready = 1'b0; prdata = 32'h12345678;
        @(negedge pclk);
        req_valid = 2'b00;
        vec++; if ({psel, penable, pwrite, paddr} !== {3'b100, 32'h80}) begin errs++; $display("FAIL rd_setup: got %b %h expected 100 80", {psel, penable, pwrite}, paddr); end
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            pready = (i == 3);
            vec++; if ({penable, rsp_valid, paddr} !== {3'b100, 32'h80}) begin errs++; $display("FAIL rd_wait%0d: got %b %h expected 100 80", i, {penable, rsp_valid}, paddr); end
        end
        @(negedge pclk);
        vec++; if ({rsp_valid, rsp_err, penable, rsp_rdata} !== {4'b0100, 32'h12345678}) begin errs++; $display("FAIL rd_rsp: got %b %h expected 0100 12345678", {rsp_valid, rsp_err, penable}, rsp_rdata); end
    endtask

    task automatic test_back_to_back;
        presetn = 1'b0;
        @(negedge pclk); @(negedge pclk);
        presetn = 1'b1; req_valid = 2'b11; req_write = 2'b11; pready = 1'b1;
        req_addr = {32'h200, 32'h100};
        for (int g = 0; g < 4; g++) begin
            #1;
            vec++; if (req_ready !== (2'b01 << (g % 2))) begin errs++; $display("FAIL b2b_grant%0d: got %b expected %b", g, req_ready, 2'b01 << (g % 2)); end
            vec++; if ({psel, penable} !== (g > 0 ? 2'b11 : 2'b00)) begin errs++; $display("FAIL b2b_bus%0d: got %b expected %b", g, {psel, penable}, g > 0 ? 2'b11 : 2'b00); end
            @(negedge pclk);
            if (g == 3) req_valid = 2'b00;
            vec++; if ({psel, penable, paddr} !== {2'b10, (g % 2) ? 32'h200 : 32'h100}) begin errs++; $display("FAIL b2b_setup%0d: got %b %h", g, {psel, penable}, paddr); end
            vec++; if (rsp_valid !== (g > 0 ? 2'b01 << ((g - 1) % 2) : 2'b00)) begin errs++; $display("FAIL b2b_rsp%0d: got %b", g, rsp_valid); end
            @(negedge pclk);
        end
        vec++; if ({req_ready, penable} !== 3'b001) begin errs++; $display("FAIL b2b_last: got %b expected 001", {req_ready, penable}); end
        @(negedge pclk);
        vec++; if ({rsp_valid, psel} !== 3'b100) begin errs++; $display("FAIL b2b_end: got %b expected 100", {rsp_valid, psel}); end
    endtask

    task automatic test_slverr;
        req_valid = 2'b10; req_write = 2'b00; req_addr[63:32] = 32'h300; prdata = 32'hA5A5A5A5; pready = 1'b1; pslverr = 1'b1;
        #1;
        vec++; if (req_ready !== 2'b10) begin errs++; $display("FAIL err_ready: got %b expected 10", req_ready); end
        @(negedge pclk); req_valid = 2'b00;
        @(negedge pclk);
        @(negedge pclk);
        pslverr = 1'b0;
        vec++; if ({rsp_valid, rsp_err, rsp_rdata} !== {3'b101, 32'hA5A5A5A5}) begin errs++; $display("FAIL err_rsp: got %b %b %h expected 10 1 a5a5a5a5", rsp_valid, rsp_err, rsp_rdata); end
        @(negedge pclk);
        vec++; if ({rsp_valid, rsp_err} !== 3'b000) begin errs++; $display("FAIL err_clear: got %b expected 000", {rsp_valid, rsp_err}); end
    endtask

    task automatic test_reset_access;
        req_valid = 2'b01; req_write = 2'b00; pready = 1'b0;
        @(negedge pclk); req_valid = 2'b00;
        @(negedge pclk);
        vec++; if (penable !== 1'b1) begin errs++; $display("FAIL rst_acc_pre: got %b expected 1", penable); end
        presetn = 1'b0;
        @(negedge pclk);
        presetn = 1'b1; pready = 1'b1;
        vec++; if ({psel, penable, rsp_valid} !== 4'b0) begin errs++; $display("FAIL rst_acc_bus: got %b expected 0000", {psel, penable, rsp_valid}); end
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            vec++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL rst_acc_norsp%0d: got %b expected 00", i, rsp_valid); end
        end
        req_valid = 2'b11;
        #1;
        vec++; if (req_ready !== 2'b01) begin errs++; $display("FAIL rst_acc_grant: got %b expected 01", req_ready); end
        @(negedge pclk); req_valid = 2'b00;
        @(negedge pclk); @(negedge pclk);
    endtask

`ifdef APB_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int n = 0;
        int k = 0;
        req_valid = 2'b01; req_write = 2'b00; pready = 1'b0; prdata = 32'hFFFFFFFF;
        @(negedge pclk); req_valid = 2'b00;
        while (k < 40 && rsp_valid == 2'b00) begin
            @(negedge pclk);
            k++;
            if (penable) n++;
        end
        vec++; if (n !== 16) begin errs++; $display("FAIL to_cycles: got %0d expected 16", n); end
        vec++; if ({rsp_valid, rsp_err, rsp_rdata} !== {3'b011, 32'h0}) begin errs++; $display("FAIL to_rsp: got %b %b %h expected 01 1 0", rsp_valid, rsp_err, rsp_rdata); end
        pready = 1'b1;
    endtask
`endif

    initial begin
        test_reset;
        test_single_write;
        test_wait_read;
        test_back_to_back;
        test_slverr;
        test_reset_access;
`ifdef APB_ARB_TIMEOUT_EN
        test_timeout;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
